// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg -- parametrised valid/ready pipeline stage register.
//
// Holds one main entry and, when SKID=1, one skid entry. Each entry has:
//   ctrl : cleared on flush
//   keep : retained across flush (e.g. PC+2)
//   ops  : NUM_OPS operand lanes. A lane of the main entry can be overwritten
//          by the shared forwarding bus while the stage is stalled.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   in_ctrl/keep/ops  upstream payload. Lane i is in_ops[i*DATA_W +: DATA_W].
//   flush             squash all held entries at the next edge
//   fwd_en, fwd_data  per-lane forward request and the shared forward value
//   out_valid/ready   downstream handshake
//   out_ctrl/keep/ops main entry payload, driven straight from flops
//   occupancy         number of held entries (0..2)
//
// pipe_stage_reg_lane holds one operand lane of the main and skid entries.
// The top instantiates NUM_OPS copies of it.
// ---------------------------------------------------------------------------
module pipe_stage_reg_lane #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_fwd,        // forward into main (already gated)
    input  logic              i_load_in,    // main <- input
    input  logic              i_load_skid,  // main <- skid
    input  logic              i_skid_load,  // skid <- input
    input  logic [DATA_W-1:0] i_in_op,
    input  logic [DATA_W-1:0] i_fwd_data,
    output logic [DATA_W-1:0] o_main
);
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            // Flush wins over forwarding, and forwarding wins over the
            // normal load source.
            if (i_flush)
                r_main <= '0;
            else if (i_fwd)
                r_main <= i_fwd_data;
            else if (i_load_in)
                r_main <= i_in_op;
            else if (i_load_skid)
                r_main <= r_skid;

            // The skid entry never sees the forwarding bus.
            if (i_flush)
                r_skid <= '0;
            else if (i_skid_load)
                r_skid <= i_in_op;
        end
    end

    assign o_main = r_main;
endmodule

module pipe_stage_reg #(
    parameter int DATA_W  = 16,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = 24,
    parameter int KEEP_W  = 16,
    parameter int SKID    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [KEEP_W-1:0]         in_keep,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic                      flush,
    input  logic [NUM_OPS-1:0]        fwd_en,
    input  logic [DATA_W-1:0]         fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [KEEP_W-1:0]         out_keep,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [1:0]                occupancy
);
    // The state encoding equals the entry count, so occupancy is the state
    // register itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_in;
    logic                w_load_skid;
    logic                w_skid_load;
    logic                w_fwd_ok;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [KEEP_W-1:0]   r_main_keep;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [KEEP_W-1:0]   r_skid_keep;

    assign out_valid  = (r_state != ST_EMPTY);
    assign occupancy  = r_state;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // With the skid entry, in_ready depends only on state, so no
    // combinational path runs from out_ready. Without it, ready passes
    // through and TWO can never be reached.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (r_state != ST_TWO);
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_EMPTY;
        else
            r_state <= w_next;
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_in_fire) w_next = ST_ONE;
            ST_ONE: begin
                if (w_in_fire && !w_out_fire)
                    w_next = ST_TWO;
                else if (!w_in_fire && w_out_fire)
                    w_next = ST_EMPTY;
            end
            ST_TWO:   if (w_out_fire) w_next = ST_ONE;
            default:  w_next = ST_EMPTY;
        endcase
        if (flush)
            w_next = ST_EMPTY;
    end

    // Load strobes. The flush gating happens at the registers.
    always_comb begin
        w_load_in   = 1'b0;
        w_load_skid = 1'b0;
        w_skid_load = 1'b0;
        case (r_state)
            ST_EMPTY: w_load_in = w_in_fire;
            ST_ONE: begin
                w_load_in   = w_in_fire & w_out_fire;
                w_skid_load = w_in_fire & ~w_out_fire;
            end
            ST_TWO:   w_load_skid = w_out_fire;
            default: ;
        endcase
    end

    // Forwarding applies only when main will hold a valid entry next cycle.
    // A flush forces EMPTY, so this also suppresses forwarding on flush.
    assign w_fwd_ok = (w_next != ST_EMPTY);

    // ctrl/keep of both entries. On flush, keep holds and ctrl clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ctrl <= '0;
            r_main_keep <= '0;
            r_skid_ctrl <= '0;
            r_skid_keep <= '0;
        end else begin
            if (flush) begin
                r_main_ctrl <= '0;
            end else if (w_load_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_keep <= in_keep;
            end else if (w_load_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_keep <= r_skid_keep;
            end

            if (flush) begin
                r_skid_ctrl <= '0;
            end else if (w_skid_load) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_keep <= in_keep;
            end
        end
    end

    assign out_ctrl = r_main_ctrl;
    assign out_keep = r_main_keep;

    generate
        for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
            pipe_stage_reg_lane #(.DATA_W(DATA_W)) u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_flush     (flush),
                .i_fwd       (fwd_en[i] & w_fwd_ok),
                .i_load_in   (w_load_in),
                .i_load_skid (w_load_skid),
                .i_skid_load (w_skid_load),
                .i_in_op     (in_ops[i*DATA_W +: DATA_W]),
                .i_fwd_data  (fwd_data),
                .o_main      (out_ops[i*DATA_W +: DATA_W])
            );
        end
    endgenerate
endmodule
